// File: rtl/serial_slave_port.sv
// serial_slave_port: responder end of the single-wire serial bus.
// Receives a master frame on rx (start, rw, address, optional write data),
// performs one local memory read or write, then returns a response on tx
// (start, status, optional read data). Half-duplex: one frame at a time.
module serial_slave_port #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              tx,
  input  logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              frame_done
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam int TO_W  = $clog2(RD_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_ZERO   = TO_W'(0);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RD_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RX_RW    = 4'd1,
    RX_ADDR  = 4'd2,
    RX_DATA  = 4'd3,
    MEM_WR   = 4'd4,
    MEM_RD   = 4'd5,
    WAIT_RD  = 4'd6,
    TX_START = 4'd7,
    TX_STAT  = 4'd8,
    TX_DATA  = 4'd9
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              rw;
  logic              err;
  logic [DATA_W-1:0] rdata;

  // Frame FSM: every output is registered, so tx shows the value chosen by
  // the state one cycle earlier; frame_done is raised together with the last
  // response bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= CNT_ZERO;
      to_cnt     <= TO_ZERO;
      rw         <= 1'b0;
      err        <= 1'b0;
      rdata      <= {DATA_W{1'b0}};
      tx         <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b0;
          bit_cnt <= CNT_ZERO;
          // A start bit in the frame_done cycle belongs to no frame.
          if (rx && !frame_done) begin
            state <= RX_RW;
          end
        end
        RX_RW: begin
          rw      <= rx;
          bit_cnt <= CNT_ZERO;
          state   <= RX_ADDR;
        end
        RX_ADDR: begin
          // LSB arrives first, so shift in from the top.
          mem_addr <= {rx, mem_addr[ADDR_W-1:1]};
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt <= CNT_ZERO;
            state   <= rw ? RX_DATA : MEM_RD;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          mem_wdata <= {rx, mem_wdata[DATA_W-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= CNT_ZERO;
            state   <= MEM_WR;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        MEM_WR: begin
          if (!busy) begin
            mem_we <= 1'b1;
            err    <= 1'b0;
            state  <= TX_START;
          end
        end
        MEM_RD: begin
          if (!busy) begin
            mem_re <= 1'b1;
            to_cnt <= TO_ZERO;
            state  <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Data arriving on the timeout cycle still wins.
          if (mem_rvalid) begin
            rdata <= mem_rdata;
            err   <= 1'b0;
            state <= TX_START;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= TX_START;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        TX_START: begin
          tx    <= 1'b1;
          state <= TX_STAT;
        end
        TX_STAT: begin
          tx <= err;
          if (!rw && !err) begin
            bit_cnt <= CNT_ZERO;
            state   <= TX_DATA;
          end else begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        TX_DATA: begin
          tx    <= rdata[0];
          rdata <= rdata >> 1;
          if (bit_cnt == DATA_LAST) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          tx    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
